// File: rtl/syn_current_pkg.sv
// Shared definitions for the synaptic current block: default sizing,
// FSM state encoding and saturation limits.
package syn_pkg;

    localparam int N_SYN_DEF        = 4;
    localparam int DECAY_SHIFT_DEF  = 3;
    localparam int DECAY_PERIOD_DEF = 8;

    localparam logic signed [7:0] SAT_MAX = 8'sh7F;
    localparam logic signed [7:0] SAT_MIN = 8'sh80;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DECAY
    } state_t;

endpackage

// File: rtl/syn_current_if.sv
// Spike, weight-write and current-output bundle of the synaptic current block.
interface syn_current_if
    import syn_pkg::*;
#(
    parameter int N_SYN = N_SYN_DEF
);
    localparam int AW = (N_SYN > 1) ? $clog2(N_SYN) : 1;

    logic [N_SYN-1:0]   spike_in;
    logic               wt_we;
    logic [AW-1:0]      wt_addr;
    logic signed [7:0]  wt_data;
    logic signed [7:0]  I_syn;
    logic               busy;

    modport master (
        output spike_in, wt_we, wt_addr, wt_data,
        input  I_syn, busy
    );

    modport slave (
        input  spike_in, wt_we, wt_addr, wt_data,
        output I_syn, busy
    );

endinterface

// File: rtl/syn_current_sat_add8.sv
// Combinational 8-bit signed adder clamped to [SAT_MIN, SAT_MAX].
module sat_add8
    import syn_pkg::*;
(
    input  logic signed [7:0] a,
    input  logic signed [7:0] b,
    output logic signed [7:0] y
);

    logic signed [8:0] sum;

    always_comb begin
        sum = {a[7], a} + {b[7], b};
        // Overflow shows as the two top bits of the 9-bit sum disagreeing
        if (sum[8] != sum[7]) begin
            y = sum[8] ? SAT_MIN : SAT_MAX;
        end else begin
            y = sum[7:0];
        end
    end

endmodule

// File: rtl/syn_current.sv
// Synaptic current accumulator: scans pending spikes through a weight file
// into a saturating accumulator, with a periodic multiplicative decay.
module syn_current
    import syn_pkg::*;
#(
    parameter int N_SYN        = N_SYN_DEF,
    parameter int DECAY_SHIFT  = DECAY_SHIFT_DEF,
    parameter int DECAY_PERIOD = DECAY_PERIOD_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    syn_current_if.slave  bus
);

    localparam int AW = (N_SYN > 1) ? $clog2(N_SYN) : 1;
    localparam int CW = $clog2(DECAY_PERIOD);
    localparam logic [AW-1:0] LAST_IDX  = AW'(N_SYN - 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(DECAY_PERIOD - 1);

    state_t            state;
    logic [AW-1:0]     idx;
    logic [N_SYN-1:0]  pending;
    logic [N_SYN-1:0]  clr;
    logic [CW-1:0]     tick_cnt;
    logic              decay_req;
    logic              busy_q;
    logic signed [7:0] acc;
    logic signed [7:0] w [N_SYN];
    logic signed [7:0] scan_sum;

    sat_add8 u_sat_add8 (
        .a (acc),
        .b (w[idx]),
        .y (scan_sum)
    );

    always_comb begin
        clr = '0;
        if (state == SCAN) begin
            clr[idx] = pending[idx];
        end
    end

    // rst_n is active-high in this codebase despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            pending   <= '0;
            tick_cnt  <= '0;
            decay_req <= 1'b0;
            busy_q    <= 1'b0;
            acc       <= '0;
            for (int unsigned i = 0; i < N_SYN; i++) begin
                w[i] <= '0;
            end
        end else begin
            pending <= (pending & ~clr) | bus.spike_in;

            if (bus.wt_we && (bus.wt_addr <= LAST_IDX)) begin
                w[bus.wt_addr] <= bus.wt_data;
            end

            tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;

            // A wrap during the DECAY edge is dropped along with the clear
            if (state == DECAY) begin
                decay_req <= 1'b0;
            end else if (tick_cnt == LAST_TICK) begin
                decay_req <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (decay_req) begin
                        state  <= DECAY;
                        busy_q <= 1'b1;
                    end else if (|pending) begin
                        state  <= SCAN;
                        idx    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (pending[idx]) begin
                        acc <= scan_sum;
                    end
                    if (idx == LAST_IDX) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DECAY: begin
                    acc    <= acc - (acc >>> DECAY_SHIFT);
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.I_syn = acc;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_syn_current.sv
// Self-checking bench for syn_current: vector table, scoreboard on scan/decay
// completion, and hand-written timing sequences.
module tb_syn_current;
    import syn_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    syn_current_if #(.N_SYN(N)) bus ();

    syn_current #(
        .N_SYN        (N),
        .DECAY_SHIFT  (3),
        .DECAY_PERIOD (1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] spike;
        int           w [N];
        int           exp;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   sb [$];
    int   mon_exp;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // A completed scan or decay is marked by busy falling; compare I_syn then
    always @(negedge clk) begin
        if (rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !bus.busy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got I_syn=%0d, expected no activity", bus.I_syn);
                end else begin
                    mon_exp = sb.pop_front();
                    check("scoreboard_I_syn", int'(bus.I_syn), mon_exp);
                end
            end
            prev_busy = bus.busy;
        end
    end

    function automatic vec_t mk(input logic [N-1:0] s, input int w0, input int w1,
                                input int w2, input int w3, input int e);
        vec_t v;
        v.spike = s;
        v.w[0]  = w0;
        v.w[1]  = w1;
        v.w[2]  = w2;
        v.w[3]  = w3;
        v.exp   = e;
        return v;
    endfunction

    task automatic do_reset();
        rst_n        = 1'b1;
        bus.spike_in = '0;
        bus.wt_we    = 1'b0;
        bus.wt_addr  = '0;
        bus.wt_data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic write_w(input int a, input int d);
        @(negedge clk);
        bus.wt_we   = 1'b1;
        bus.wt_addr = 2'(a);
        bus.wt_data = 8'(d);
        @(negedge clk);
        bus.wt_we   = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] p);
        @(negedge clk);
        bus.spike_in = p;
        @(negedge clk);
        bus.spike_in = '0;
    endtask

    task automatic drain(input string name, input int maxc);
        int c = 0;
        while (sb.size() != 0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d results outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs [7];
    int   dec_start [6] = '{64, -8, -1, 5, -128, 127};
    int   dec_exp   [6] = '{56, -7,  0, 5, -112, 112};
    logic [N-1:0] busy_pat = 4'b0000;

    initial begin
        vecs[0] = mk(4'b0001,   20,    0,    0,    0,   20);
        vecs[1] = mk(4'b1111,  100,  100,  100,  100,  127);
        vecs[2] = mk(4'b1111, -100, -100, -100, -100, -128);
        vecs[3] = mk(4'b0110,   10,   -3,    7,    1,    4);
        vecs[4] = mk(4'b0111,  127,    1, -128,    0,   -1);
        vecs[5] = mk(4'b1011,  -50,  -60,   30,    5, -105);
        vecs[6] = mk(4'b1000,    0,    0,    0,   -1,   -1);

        bus.spike_in = '0;
        bus.wt_we    = 1'b0;
        bus.wt_addr  = '0;
        bus.wt_data  = '0;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        check("reset_I_syn", int'(bus.I_syn), 0);
        check("reset_busy", int'(bus.busy), 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            for (int k = 0; k < N; k++) write_w(k, vecs[i].w[k]);
            sb.push_back(vecs[i].exp);
            pulse(vecs[i].spike);
            drain($sformatf("vec%0d", i), 20);
            check($sformatf("vec%0d_I_syn", i), int'(bus.I_syn), vecs[i].exp);
            check($sformatf("vec%0d_busy", i), int'(bus.busy), 0);
        end

        // Single spike on bit 0: busy profile and first-update latency
        do_reset();
        write_w(0, 20);
        sb.push_back(20);
        pulse(4'b0001);
        check("seq_N0_busy", int'(bus.busy), 0);
        check("seq_N0_I_syn", int'(bus.I_syn), 0);
        @(negedge clk);
        check("seq_N1_I_syn", int'(bus.I_syn), 0);
        check("seq_N1_busy", int'(bus.busy), 1);
        @(negedge clk);
        check("seq_N2_I_syn", int'(bus.I_syn), 20);
        for (int j = 0; j < N; j++) begin
            busy_pat[j] = bus.busy;
            if (j < N - 1) @(negedge clk);
        end
        check("seq_busy_N2_to_N5", int'(busy_pat), 4'b0111);
        drain("seq", 10);

        for (int k = 0; k < N; k++) begin
            do_reset();
            write_w(k, k + 1);
            sb.push_back(k + 1);
            pulse(N'(1 << k));
            repeat (k + 1) @(negedge clk);
            check($sformatf("lat%0d_before", k), int'(bus.I_syn), 0);
            @(negedge clk);
            check($sformatf("lat%0d_after", k), int'(bus.I_syn), k + 1);
            drain($sformatf("lat%0d", k), 20);
        end

        do_reset();
        for (int k = 0; k < N; k++) write_w(k, -100);
        for (int r = 0; r < 3; r++) begin
            sb.push_back(-128);
            pulse(4'b1111);
            drain("sat_hold", 20);
        end
        check("sat_hold_I_syn", int'(bus.I_syn), -128);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            write_w(0, dec_start[i]);
            sb.push_back(dec_start[i]);
            pulse(4'b0001);
            drain("decay_load", 20);
            sb.push_back(dec_exp[i]);
            drain($sformatf("decay%0d", i), 1200);
            check($sformatf("decay%0d_I_syn", i), int'(bus.I_syn), dec_exp[i]);
        end

        do_reset();
        write_w(0, 64);
        sb.push_back(64);
        pulse(4'b0001);
        drain("chain_load", 20);
        sb.push_back(56);
        sb.push_back(49);
        sb.push_back(43);
        drain("decay_chain", 3500);

        // Spike on bit 2 held across the edge that clears it
        do_reset();
        write_w(2, 5);
        sb.push_back(5);
        sb.push_back(10);
        pulse(4'b0100);
        repeat (3) @(negedge clk);
        bus.spike_in = 4'b0100;
        @(negedge clk);
        bus.spike_in = '0;
        drain("repend", 30);
        check("repend_I_syn", int'(bus.I_syn), 10);

        // Weight rewritten on the edge that consumes it
        do_reset();
        write_w(1, 10);
        sb.push_back(10);
        pulse(4'b0010);
        @(negedge clk);
        @(negedge clk);
        bus.wt_we   = 1'b1;
        bus.wt_addr = 2'd1;
        bus.wt_data = 8'sd30;
        @(negedge clk);
        bus.wt_we   = 1'b0;
        drain("wt_race", 20);
        check("wt_race_I_syn", int'(bus.I_syn), 10);
        sb.push_back(40);
        pulse(4'b0010);
        drain("wt_new", 20);
        check("wt_new_I_syn", int'(bus.I_syn), 40);

        // Asynchronous reset in the middle of a scan
        do_reset();
        write_w(0, 50);
        write_w(3, 1);
        pulse(4'b1001);
        @(negedge clk);
        @(negedge clk);
        check("midscan_I_syn", int'(bus.I_syn), 50);
        check("midscan_busy", int'(bus.busy), 1);
        #2 rst_n = 1'b1;
        #1;
        check("async_rst_I_syn", int'(bus.I_syn), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        write_w(3, 9);
        repeat (4) @(negedge clk);
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_I_syn", int'(bus.I_syn), 0);
        sb.push_back(9);
        pulse(4'b1001);
        drain("post_rst", 20);
        check("post_rst_scan", int'(bus.I_syn), 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/syn_current.md
SYN_CURRENT -- requirements
Module: syn_current

Interface
REQ-001 Parameter N_SYN, default 4: number of presynaptic spike inputs.
REQ-002 Parameter DECAY_SHIFT, default 3: decay factor, where acc loses acc>>>DECAY_SHIFT per decay step.
REQ-003 Parameter DECAY_PERIOD, default 8: clk cycles between decay ticks; must be at least 2.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset: asynchronous, active-high.
REQ-006 spike_in  input  N_SYN  presynaptic spikes, one bit per synapse, sampled each edge.
REQ-007 wt_we  input  1  weight write enable.
REQ-008 wt_addr  input  clog2(N_SYN)  weight index to write.
REQ-009 wt_data  input  8  signed weight value.
REQ-010 I_syn  output  8  signed synaptic current, driven directly from the acc register; feeds the downstream membrane integrator.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Weight file: N_SYN x 8-bit signed registers; when wt_we=1, w[wt_addr] is written at the edge; a weight written at edge E is first used by a scan step after E.
REQ-013 Pending register: at every edge, pending <= (pending & ~clr) | spike_in; a spike arriving on bit k in the same edge that clears bit k leaves bit k set.
REQ-014 Tick counter: free-running over 0..DECAY_PERIOD-1; on each wrap to 0, decay_req is set; a wrap while decay_req is already 1 is dropped and not counted.
REQ-015 FSM states: IDLE, SCAN, DECAY.
REQ-016 IDLE transitions, in priority order: decay_req=1 -> DECAY; else pending!=0 -> SCAN with idx=0; else stay in IDLE.
REQ-017 SCAN step, one edge per index: if pending[idx]=1, then acc <= sat8(acc + w[idx]) and clr[idx]=1. idx increments. The step at idx=N_SYN-1 returns to IDLE.
REQ-018 A SCAN in progress always completes; a decay_req raised during SCAN waits until IDLE.
REQ-019 DECAY: a single edge performing acc <= acc - (acc>>>DECAY_SHIFT), arithmetic shift (floor); decay_req is cleared; next state is IDLE.
REQ-020 Decay consequences at DECAY_SHIFT=3: positive acc in 1..7 is unchanged; acc=-1 becomes 0; acc=-8 becomes -7. This is required, not a defect.
REQ-021 sat8: compute a 9-bit signed sum, then clamp to the range [-128, +127].
REQ-022 Latency: a spike on bit k sampled at edge E0 (with FSM idle and no decay_req) updates I_syn after edge E0+2+k.
REQ-023 busy and I_syn are registered outputs with no combinational path from any input.

Reset
REQ-024 While rst_n=1, with no clock required:
- acc, I_syn, all weights, pending, decay_req and the tick counter are 0
- state is IDLE, busy is 0
REQ-025 Reset asserted mid-SCAN or mid-DECAY discards all pending spikes and any partial accumulation.
REQ-026 On release, the first tick occurs DECAY_PERIOD edges after the first post-reset edge.

Structure
REQ-027 Shared package syn_pkg holds the default N_SYN, DECAY_SHIFT and DECAY_PERIOD, the FSM state enum, and the SAT_MAX=127 / SAT_MIN=-128 constants.
REQ-028 One sub-module, sat_add8, is a combinational 8-bit signed saturating adder instantiated for the SCAN accumulation.
REQ-029 Target size is 120-400 lines of RTL with a single clock domain.

Verification
REQ-030 Scenario: set DECAY_PERIOD=1000, w0=20, pulse spike_in=0001 for 1 cycle -> I_syn=20 two edges later, busy high for 4 edges.
REQ-031 Scenario: all weights set to 100, spike_in=1111 -> I_syn=127. Then set all weights to -100 and spike repeatedly -> I_syn reaches -128 and holds.
REQ-032 Scenario: acc=64, DECAY_SHIFT=3, no spikes -> I_syn takes the values 56, 49, 43 on successive ticks. Start from acc=-8 -> I_syn becomes -7.
REQ-033 Scenario: w2=5, spike on bit 2 held during the edge SCAN processes idx 2 -> bit 2 is re-pended and a second scan adds again, giving I_syn=10.
REQ-034 Scenario: w1=10, write w1=30 on the same edge SCAN processes idx 1 -> I_syn=10.
REQ-035 Scenario: assert rst_n=1 mid-SCAN with I_syn=50 -> I_syn=0, busy=0 and weights 0 immediately, without waiting for a clock edge.
